// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF_ID pipeline register for the 5-stage RV32I core.
// Owns the PC, drives the instruction-memory request/ready handshake, buffers one
// word fetched during a stall, and applies branch redirects from the decode stage.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchFlag,
  input  logic [31:0] branchAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic [31:0] ifidPc,
  output logic [31:0] ifidInst,
  output logic        ifidValid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] hpc_r;
  logic [31:0] hinst_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_inst_r;
  logic        ifid_valid_r;

  logic [31:0] pc_next_s;
  logic [31:0] branch_target_s;
  logic        redirect_s;

  // PC increment wraps modulo 2^32; branch targets are forced word-aligned.
  assign pc_next_s       = pc_r + 32'd4;
  assign branch_target_s = branchAddr & 32'hFFFF_FFFC;
  // A branch is only honoured when the pipeline is not stalled; the branch unit re-asserts.
  assign redirect_s      = branchFlag & ~stall;

  // The request follows the state register directly and is forced low during reset.
  assign imemReq   = (state_r == FETCH) & ~rst;
  assign imemAddr  = pc_r;
  assign ifidPc    = ifid_pc_r;
  assign ifidInst  = ifid_inst_r;
  assign ifidValid = ifid_valid_r;

  // Fetch FSM, PC, hold buffer and IF_ID register; priority is reset > redirect > stall > fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      hpc_r        <= 32'h0000_0000;
      hinst_r      <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_inst_r  <= NOP_INST;
      ifid_valid_r <= 1'b0;
    end else if (redirect_s) begin
      // Redirect drops any same-cycle memory response and any buffered word.
      state_r      <= FETCH;
      pc_r         <= branch_target_s;
      hpc_r        <= 32'h0000_0000;
      hinst_r      <= 32'h0000_0000;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_inst_r  <= NOP_INST;
      ifid_valid_r <= 1'b0;
    end else if (stall) begin
      case (state_r)
        FETCH: begin
          // Capture a word that arrives while IF_ID is frozen so it is not lost.
          if (imemReady) begin
            hpc_r   <= pc_r;
            hinst_r <= imemData;
            pc_r    <= pc_next_s;
            state_r <= HOLD;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          state_r <= HOLD;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (imemReady) begin
            ifid_pc_r    <= pc_r;
            ifid_inst_r  <= imemData;
            ifid_valid_r <= 1'b1;
            pc_r         <= pc_next_s;
          end else begin
            // Memory not ready: insert a bubble tagged with the pending PC.
            ifid_pc_r    <= pc_r;
            ifid_inst_r  <= NOP_INST;
            ifid_valid_r <= 1'b0;
          end
          state_r <= FETCH;
        end
        HOLD: begin
          // Release the buffered word; fetch resumes at the already-advanced PC.
          ifid_pc_r    <= hpc_r;
          ifid_inst_r  <= hinst_r;
          ifid_valid_r <= 1'b1;
          state_r      <= FETCH;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, stall/hold, branch redirect,
// stalled branch, branch in HOLD, memory wait bubbles, PC wrap and asynchronous reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchFlag;
  logic [31:0] branchAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] ifidPc;
  logic [31:0] ifidInst;
  logic        ifidValid;

  int total;
  int bad;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .branchFlag(branchFlag),
    .branchAddr(branchAddr),
    .imemReady (imemReady),
    .imemData  (imemData),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .ifidPc    (ifidPc),
    .ifidInst  (ifidInst),
    .ifidValid (ifidValid)
  );

  // Memory content is a fixed function of the address so every word is distinguishable.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  assign imemData = word_at(imemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a valid IF_ID entry for the given PC.
  task automatic chk_valid(input string tag, input logic [31:0] p);
    chk({tag, ".pc"}, ifidPc, p);
    chk({tag, ".inst"}, ifidInst, word_at(p));
    chk({tag, ".valid"}, {31'd0, ifidValid}, 32'd1);
  endtask

  // Checks a bubble in IF_ID with the given tagged PC.
  task automatic chk_bubble(input string tag, input logic [31:0] p);
    chk({tag, ".pc"}, ifidPc, p);
    chk({tag, ".inst"}, ifidInst, NOP);
    chk({tag, ".valid"}, {31'd0, ifidValid}, 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    stall      = 1'b0;
    branchFlag = 1'b0;
    branchAddr = 32'h0000_0000;
    imemReady  = 1'b1;

    // Reset state
    step();
    step();
    chk("rst.req", {31'd0, imemReq}, 32'd0);
    chk("rst.addr", imemAddr, 32'h0000_0000);
    chk_bubble("rst", 32'h0000_0000);
    rst = 1'b0;
    #1;
    chk("rel.req", {31'd0, imemReq}, 32'd1);

    // Sequential fetch, one word per cycle
    for (int i = 0; i < 4; i++) begin
      step();
      chk_valid("seq", 32'(i * 4));
      chk("seq.addr", imemAddr, 32'(i * 4 + 4));
    end

    // Stall two cycles while memory is ready at pc=0x10
    stall = 1'b1;
    step();
    chk_valid("stall1", 32'h0000_000C);
    chk("stall1.req", {31'd0, imemReq}, 32'd0);
    chk("stall1.addr", imemAddr, 32'h0000_0014);
    step();
    chk_valid("stall2", 32'h0000_000C);
    chk("stall2.addr", imemAddr, 32'h0000_0014);
    stall = 1'b0;
    step();
    chk_valid("hold_rel", 32'h0000_0010);
    chk("hold_rel.req", {31'd0, imemReq}, 32'd1);
    step();
    chk_valid("after_hold", 32'h0000_0014);

    // Branch with ready response at pc=0x18; unaligned target is word-aligned
    branchFlag = 1'b1;
    branchAddr = 32'h0000_0103;
    step();
    chk_bubble("br", 32'h0000_0000);
    chk("br.addr", imemAddr, 32'h0000_0100);
    branchFlag = 1'b0;
    step();
    chk_valid("br_tgt", 32'h0000_0100);

    // Branch during stall is ignored, taken once stall drops
    stall      = 1'b1;
    branchFlag = 1'b1;
    branchAddr = 32'h0000_0200;
    imemReady  = 1'b0;
    step();
    chk("brst.addr", imemAddr, 32'h0000_0104);
    chk_valid("brst", 32'h0000_0100);
    stall = 1'b0;
    step();
    chk_bubble("brst_go", 32'h0000_0000);
    chk("brst_go.addr", imemAddr, 32'h0000_0200);
    branchFlag = 1'b0;

    // Branch while in HOLD discards the held word
    imemReady = 1'b1;
    stall     = 1'b1;
    step();
    chk("hold.req", {31'd0, imemReq}, 32'd0);
    chk("hold.addr", imemAddr, 32'h0000_0204);
    stall      = 1'b0;
    branchFlag = 1'b1;
    branchAddr = 32'h0000_0300;
    step();
    chk_bubble("hold_br", 32'h0000_0000);
    chk("hold_br.addr", imemAddr, 32'h0000_0300);
    chk("hold_br.req", {31'd0, imemReq}, 32'd1);
    branchFlag = 1'b0;
    step();
    chk_valid("hold_br_tgt", 32'h0000_0300);

    // Memory not ready for 3 cycles: bubbles and stable address
    imemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bubble("wait", 32'h0000_0304);
      chk("wait.addr", imemAddr, 32'h0000_0304);
    end
    imemReady = 1'b1;
    step();
    chk_valid("wait_end", 32'h0000_0304);

    // PC wrap at the top of the address space
    branchFlag = 1'b1;
    branchAddr = 32'hFFFF_FFFC;
    step();
    chk("wrap.addr0", imemAddr, 32'hFFFF_FFFC);
    branchFlag = 1'b0;
    step();
    chk_valid("wrap", 32'hFFFF_FFFC);
    chk("wrap.addr", imemAddr, 32'h0000_0000);

    // Asynchronous reset between clock edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst.req", {31'd0, imemReq}, 32'd0);
    chk("arst.addr", imemAddr, 32'h0000_0000);
    chk_bubble("arst", 32'h0000_0000);
    step();
    rst = 1'b0;
    #1;
    chk("arst_rel.req", {31'd0, imemReq}, 32'd1);
    step();
    chk_valid("restart", 32'h0000_0000);
    chk("restart.addr", imemAddr, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
